// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared states, element encodings and unit counts for the Morse keyer
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        CHAR_GAP
    } state_t;

    localparam logic DOT  = 1'b0;
    localparam logic DASH = 1'b1;

    localparam int DOT_UNITS   = 1;
    localparam int DASH_UNITS  = 3;
    localparam int SPACE_UNITS = 1;
    localparam int ELEMENTS    = 5;

    // Index of the final unit of a mark, as compared against the 2-bit unit counter.
    function automatic logic [1:0] mark_last_unit(input logic elem);
        return (elem == DASH) ? 2'(DASH_UNITS - 1) : 2'(DOT_UNITS - 1);
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// rtl/morse_unit_timer.sv - cycle divider producing one tick per Morse time unit
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(UNIT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/transmissor_morse.sv
// rtl/transmissor_morse.sv - Morse keyer for 5-element code words; MORSE_TONE_EN adds a tone output
module transmissor_morse
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES    = 4,
    parameter int CHAR_GAP_UNITS = 3
`ifdef MORSE_TONE_EN
    ,
    parameter int TONE_DIV       = 2
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic ready,
    input  logic X1,
    input  logic X2,
    input  logic X3,
    input  logic X4,
    input  logic X5,
    output logic key,
    output logic busy,
    output logic done
`ifdef MORSE_TONE_EN
    ,
    output logic tone
`endif
);

    state_t      state;
    logic [4:0]  code;
    logic [1:0]  units;
    logic [2:0]  idx;
    logic [1:0]  last_unit;
    logic        tick;
    logic        leave;
    logic        accept;
    logic        restart;

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .tick   (tick)
    );

    // code[4] always holds the element currently being keyed.
    always_comb begin
        last_unit = 2'd0;
        case (state)
            MARK:     last_unit = mark_last_unit(code[4]);
            SPACE:    last_unit = 2'(SPACE_UNITS - 1);
            CHAR_GAP: last_unit = 2'(CHAR_GAP_UNITS - 1);
            default:  last_unit = 2'd0;
        endcase
    end

    assign accept  = (state == IDLE) && ready;
    assign leave   = (state != IDLE) && tick && (units == last_unit);
    assign restart = accept || leave;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            code  <= '0;
            units <= '0;
            idx   <= '0;
            key   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (leave) begin
                units <= '0;
            end else if (tick && state != IDLE) begin
                units <= units + 2'd1;
            end
            case (state)
                IDLE: begin
                    if (ready) begin
                        code  <= {X1, X2, X3, X4, X5};
                        idx   <= '0;
                        units <= '0;
                        key   <= 1'b1;
                        busy  <= 1'b1;
                        state <= MARK;
                    end
                end
                MARK: begin
                    if (leave) begin
                        key   <= 1'b0;
                        state <= (idx < 3'(ELEMENTS - 1)) ? SPACE : CHAR_GAP;
                    end
                end
                SPACE: begin
                    if (leave) begin
                        idx   <= idx + 3'd1;
                        code  <= {code[3:0], 1'b0};
                        key   <= 1'b1;
                        state <= MARK;
                    end
                end
                CHAR_GAP: begin
                    if (leave) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MORSE_TONE_EN
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    logic [TW-1:0] tone_cnt;
    logic          mark_entry;

    assign mark_entry = accept || (state == SPACE && leave);

    always_ff @(posedge clk) begin
        if (reset || mark_entry || state != MARK || leave) begin
            tone     <= 1'b0;
            tone_cnt <= '0;
        end else if (tone_cnt == TW'(TONE_DIV - 1)) begin
            tone     <= ~tone;
            tone_cnt <= '0;
        end else begin
            tone_cnt <= tone_cnt + TW'(1);
        end
    end
`endif

endmodule
